// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell stepped over WIDTH cycles, LSB first,
// with a start/ready handshake and a one-cycle done pulse on result delivery.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
    logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
    logic [WIDTH-1:0]   psum_reg, psum_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               carry_reg, carry_next;
    logic               c_out_reg, c_out_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               fa_s, fa_c;
    logic [WIDTH-1:0]   psum_shift;
    logic               last_bit;

    full_adder u_fa (
        .a     (a_sh_reg[0]),
        .b     (b_sh_reg[0]),
        .c_in  (carry_reg),
        .s     (fa_s),
        .c_out (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH steps the first bit sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign psum_shift = fa_s;
        end else begin : g_wn
            assign psum_shift = {fa_s, psum_reg[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        psum_next  = psum_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        c_out_next = c_out_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b;
                    carry_next = c_in;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                psum_next  = psum_shift;
                carry_next = fa_c;
                a_sh_next  = a_sh_reg >> 1;
                b_sh_next  = b_sh_reg >> 1;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (last_bit) begin
                    sum_next   = psum_shift;
                    c_out_next = fa_c;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            psum_reg  <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            c_out_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            psum_reg  <= psum_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            c_out_reg <= c_out_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign ready = (state_reg != RUN);
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign sum   = sum_reg;
    assign c_out = c_out_reg;
endmodule
